// File: rtl/spi_pixel_stream_pkg.sv
// Shared defaults and the controller state type for the SPI pixel streaming block.
package spi_pixel_stream_pkg;

   localparam int PIXEL_BITS_DEF  = 8;
   localparam int CHANNELS_DEF    = 1;
   localparam int FIFO_DEPTH_DEF  = 4;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

endpackage

// File: rtl/spi_pixel_stream_fifo.sv
// Return-pixel buffer: single-clock FIFO with a combinational head.
// A pop on an empty FIFO is ignored; a push on a full FIFO is dropped unless a
// pop happens in the same cycle.
module px_sync_fifo
   import spi_pixel_stream_pkg::*;
#(
   parameter int  WIDTH = PIXEL_BITS_DEF,
   parameter int  DEPTH = FIFO_DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             nreset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign full_o    = (r_level == LW'(DEPTH));
   assign empty_o   = (r_level == '0);
   assign level_o   = r_level;
   assign head_o    = r_mem[r_rptr];
   assign w_do_pop  = pop_i && !empty_o;
   assign w_do_push = push_i && (!full_o || w_do_pop);

   // Storage array: data only, no reset needed
   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wptr] <= push_data_i;
   end

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
         else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
      end
   end

endmodule

// File: rtl/spi_pixel_stream.sv
// SPI mode-0 slave that receives pixel words on SDI and returns processed pixels
// from a small FIFO on SDO. All SPI inputs are oversampled by clk_i.
module spi_pixel_stream
   import spi_pixel_stream_pkg::*;
#(
   parameter int  PIXEL_BITS  = PIXEL_BITS_DEF,
   parameter int  CHANNELS    = CHANNELS_DEF,
   parameter int  FIFO_DEPTH  = FIFO_DEPTH_DEF,
   parameter int  SYNC_STAGES = SYNC_STAGES_DEF,
   localparam int W           = PIXEL_BITS * CHANNELS,
   localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          nreset_i,
   input  logic          spi_sck_i,
   input  logic          spi_cs_i,
   input  logic          spi_sdi_i,
   output logic          spi_sdo_o,
   output logic [W-1:0]  in_px_o,
   output logic          in_valid_o,
   input  logic [W-1:0]  out_px_i,
   input  logic          out_valid_i,
   output logic [LW-1:0] fifo_level_o,
   output logic          ovf_o,
   output logic          udf_o,
   input  logic          clr_flags_i
);

   localparam int            CW       = $clog2(W + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sdi_sync;
   logic                   r_sck_prev;
   logic                   r_cs_prev;
   logic [SYNC_STAGES-1:0] r_flush;
   logic                   r_cs_armed;

   state_t                 r_state;
   state_t                 w_next;
   logic [CW-1:0]          r_bitcnt;
   logic                   r_reload;
   logic [W-1:0]           r_rx;
   logic [W-1:0]           r_tx;
   logic [W-1:0]           r_in_px;
   logic                   r_in_valid;
   logic                   r_ovf;
   logic                   r_udf;

   logic                   w_sck, w_cs, w_sdi;
   logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
   logic                   w_pop, w_load_tx, w_shift_tx, w_rx_shift;
   logic                   w_word_done;
   logic [W-1:0]           w_rx_next;
   logic [W-1:0]           w_fifo_head;
   logic [W-1:0]           w_tx_src;
   logic                   w_fifo_full, w_fifo_empty;
   logic                   w_ovf_evt, w_udf_evt;

   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_cs       = r_cs_sync[SYNC_STAGES-1];
   assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
   assign w_sck_rise = w_sck && !r_sck_prev;
   assign w_sck_fall = !w_sck && r_sck_prev;
   assign w_cs_rise  = w_cs && !r_cs_prev;
   assign w_cs_fall  = !w_cs && r_cs_prev;

   // Input synchronisers and edge-detect history, reset to bus-idle levels
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_sck_sync <= '0;
         r_cs_sync  <= '1;
         r_sdi_sync <= '0;
         r_sck_prev <= 1'b0;
         r_cs_prev  <= 1'b1;
      end else begin
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_i};
         r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
         r_sck_prev <= w_sck;
         r_cs_prev  <= w_cs;
      end
   end

   // Arm frame start only after a real CS-high has been seen post reset, so a
   // reset in the middle of a frame never resumes on the tail of that frame
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_flush    <= '0;
         r_cs_armed <= 1'b0;
      end else begin
         r_flush <= {r_flush[SYNC_STAGES-2:0], 1'b1};
         if (r_flush[SYNC_STAGES-1] && w_cs) r_cs_armed <= 1'b1;
      end
   end

   // Controller state register
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) r_state <= ST_IDLE;
      else           r_state <= w_next;
   end

   // Next state and per-cycle datapath strobes; CS rise always wins
   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_load_tx  = 1'b0;
      w_shift_tx = 1'b0;
      w_rx_shift = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_fall && r_cs_armed) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            if (w_cs_rise) begin
               w_next = ST_IDLE;
            end else begin
               w_next    = ST_SHIFT;
               w_pop     = 1'b1;
               w_load_tx = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_cs_rise) begin
               w_next = ST_IDLE;
            end else begin
               w_rx_shift = w_sck_rise;
               if (w_sck_fall) begin
                  if (r_reload) begin
                     w_pop     = 1'b1;
                     w_load_tx = 1'b1;
                  end else begin
                     w_shift_tx = 1'b1;
                  end
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_word_done = w_rx_shift && (r_bitcnt == LAST_BIT);
   assign w_rx_next   = {r_rx[W-2:0], w_sdi};
   assign w_tx_src    = w_fifo_empty ? '0 : w_fifo_head;
   assign w_udf_evt   = w_pop && w_fifo_empty;
   assign w_ovf_evt   = out_valid_i && w_fifo_full && !w_pop;

   // Bit counter and word-boundary reload request; cleared outside SHIFT
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_bitcnt <= '0;
         r_reload <= 1'b0;
      end else if (r_state != ST_SHIFT || w_cs_rise) begin
         r_bitcnt <= '0;
         r_reload <= 1'b0;
      end else if (w_rx_shift) begin
         if (w_word_done) begin
            r_bitcnt <= '0;
            r_reload <= 1'b1;
         end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
         end
      end else if (w_load_tx) begin
         r_reload <= 1'b0;
      end
   end

   // RX and TX shift registers: pure data, no reset
   always_ff @(posedge clk_i) begin
      if (w_rx_shift) r_rx <= w_rx_next;
      if (w_load_tx)       r_tx <= w_tx_src;
      else if (w_shift_tx) r_tx <= {r_tx[W-2:0], 1'b0};
   end

   // Received-word output register and its one-cycle strobe
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_in_px    <= '0;
         r_in_valid <= 1'b0;
      end else begin
         r_in_valid <= w_word_done;
         if (w_word_done) r_in_px <= w_rx_next;
      end
   end

   // Sticky error flags; a new event takes priority over a clear
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= w_ovf_evt || (r_ovf && !clr_flags_i);
         r_udf <= w_udf_evt || (r_udf && !clr_flags_i);
      end
   end

   px_sync_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .nreset_i    (nreset_i),
      .push_i      (out_valid_i),
      .push_data_i (out_px_i),
      .pop_i       (w_pop),
      .head_o      (w_fifo_head),
      .full_o      (w_fifo_full),
      .empty_o     (w_fifo_empty),
      .level_o     (fifo_level_o)
   );

   assign spi_sdo_o  = (r_state == ST_SHIFT) ? r_tx[W-1] : 1'b0;
   assign in_px_o    = r_in_px;
   assign in_valid_o = r_in_valid;
   assign ovf_o      = r_ovf;
   assign udf_o      = r_udf;

endmodule
